// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the code ROM address and captures the IR.
// Optional 1-entry prefetch buffer enabled by defining IFU_PREFETCH_EN.
module instr_fetch_unit #(
   parameter int PC_WIDTH = 9,
   parameter int INSTR_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b0}}
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_fetch_req,
   input  logic                   in_pc_load,
   input  logic [PC_WIDTH-1:0]    in_pc_value,
   output logic [PC_WIDTH-1:0]    out_code_mem_addr,
   input  logic [INSTR_WIDTH-1:0] in_code_mem_data,
   output logic [INSTR_WIDTH-1:0] out_ir,
   output logic                   out_ir_valid,
   output logic [PC_WIDTH-1:0]    out_pc,
   output logic                   out_busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state_r, state_nxt;
   logic [PC_WIDTH-1:0]    pc_r, pc_nxt;
   logic [INSTR_WIDTH-1:0] ir_r, ir_nxt;
   logic                   ir_valid_r, ir_valid_nxt;
   logic                   busy_r;

`ifdef IFU_PREFETCH_EN
   // bg_r: 0 = no background read, 1 = address on ROM, 2 = data returning
   logic [1:0]             bg_r, bg_nxt;
   logic [INSTR_WIDTH-1:0] pf_data_r, pf_data_nxt;
   logic                   pf_valid_r, pf_valid_nxt;
`endif

   // State, PC, IR and status registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         pc_r       <= RESET_VECTOR;
         ir_r       <= {INSTR_WIDTH{1'b0}};
         ir_valid_r <= 1'b0;
         busy_r     <= 1'b0;
`ifdef IFU_PREFETCH_EN
         bg_r       <= 2'd0;
         pf_data_r  <= {INSTR_WIDTH{1'b0}};
         pf_valid_r <= 1'b0;
`endif
      end else begin
         state_r    <= state_nxt;
         pc_r       <= pc_nxt;
         ir_r       <= ir_nxt;
         ir_valid_r <= ir_valid_nxt;
         busy_r     <= (state_nxt != ST_IDLE);
`ifdef IFU_PREFETCH_EN
         bg_r       <= bg_nxt;
         pf_data_r  <= pf_data_nxt;
         pf_valid_r <= pf_valid_nxt;
`endif
      end
   end

   // Next-state logic; a PC load always wins and aborts any fetch in flight
   always_comb begin
      state_nxt    = state_r;
      pc_nxt       = pc_r;
      ir_nxt       = ir_r;
      ir_valid_nxt = 1'b0;
`ifdef IFU_PREFETCH_EN
      bg_nxt       = 2'd0;
      pf_data_nxt  = pf_data_r;
      pf_valid_nxt = pf_valid_r;
      if (bg_r == 2'd1) begin
         bg_nxt = 2'd2;
      end else if (bg_r == 2'd2) begin
         pf_data_nxt  = in_code_mem_data;
         pf_valid_nxt = 1'b1;
      end else begin
         bg_nxt = 2'd0;
      end
`endif
      case (state_r)
         ST_IDLE: begin
            if (in_pc_load) begin
               pc_nxt = in_pc_value;
`ifdef IFU_PREFETCH_EN
               bg_nxt       = 2'd0;
               pf_valid_nxt = 1'b0;
            end else if (in_fetch_req && pf_valid_r) begin
               ir_nxt       = pf_data_r;
               ir_valid_nxt = 1'b1;
               pc_nxt       = pc_r + PC_ONE;
               pf_valid_nxt = 1'b0;
               bg_nxt       = 2'd1;
`endif
            end else if (in_fetch_req) begin
               state_nxt = ST_WAIT;
`ifdef IFU_PREFETCH_EN
               bg_nxt       = 2'd0;
               pf_valid_nxt = 1'b0;
`endif
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (in_pc_load) begin
               pc_nxt    = in_pc_value;
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            state_nxt = ST_IDLE;
            if (in_pc_load) begin
               pc_nxt = in_pc_value;
            end else begin
               ir_nxt       = in_code_mem_data;
               ir_valid_nxt = 1'b1;
               pc_nxt       = pc_r + PC_ONE;
`ifdef IFU_PREFETCH_EN
               bg_nxt = 2'd1;
`endif
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign out_code_mem_addr = pc_r;
   assign out_pc            = pc_r;
   assign out_ir            = ir_r;
   assign out_ir_valid      = ir_valid_r;
   assign out_busy          = busy_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a behavioural synchronous ROM.
// Prefetch scenarios run only when IFU_PREFETCH_EN is defined.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_fetch_req;
   logic        in_pc_load;
   logic [8:0]  in_pc_value;
   logic [8:0]  out_code_mem_addr;
   logic [15:0] in_code_mem_data;
   logic [15:0] out_ir;
   logic        out_ir_valid;
   logic [8:0]  out_pc;
   logic        out_busy;

   logic [15:0] rom [0:511];
   int checks = 0;
   int errors = 0;

   instr_fetch_unit dut (
      .clk(clk), .reset(reset), .in_fetch_req(in_fetch_req), .in_pc_load(in_pc_load),
      .in_pc_value(in_pc_value), .out_code_mem_addr(out_code_mem_addr),
      .in_code_mem_data(in_code_mem_data), .out_ir(out_ir), .out_ir_valid(out_ir_valid),
      .out_pc(out_pc), .out_busy(out_busy)
   );

   always #5 clk = ~clk;

   // Synchronous ROM with one cycle of read latency
   always @(posedge clk) in_code_mem_data <= rom[out_code_mem_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_pc(input logic [8:0] v);
      in_pc_load = 1'b1; in_pc_value = v;
      tick();
      in_pc_load = 1'b0;
      check("load_pc", 32'(out_pc), 32'(v));
   endtask

   // Normal-path fetch: result must appear exactly three cycles after the request
   task automatic do_fetch(input string tag, input logic [15:0] exp_ir, input logic [8:0] exp_pc);
      in_fetch_req = 1'b1;
      tick();
      in_fetch_req = 1'b0;
      check({tag, "_busy1"}, 32'(out_busy), 32'd1);
      check({tag, "_v1"}, 32'(out_ir_valid), 32'd0);
      tick();
      check({tag, "_v2"}, 32'(out_ir_valid), 32'd0);
      tick();
      check({tag, "_v3"}, 32'(out_ir_valid), 32'd1);
      check({tag, "_ir"}, 32'(out_ir), 32'(exp_ir));
      check({tag, "_pc"}, 32'(out_pc), 32'(exp_pc));
      check({tag, "_busy0"}, 32'(out_busy), 32'd0);
      tick();
      check({tag, "_v4"}, 32'(out_ir_valid), 32'd0);
   endtask

   initial begin
      int pulses;
      for (int i = 0; i < 512; i++) rom[i] = 16'(i) ^ 16'h5A00;
      rom[9'h000] = 16'h4A11;
      rom[9'h1F0] = 16'hE3F0;
      rom[9'h1FF] = 16'h8000;
      rom[9'h005] = 16'h1234;
      rom[9'h003] = 16'h0BEE;
      reset = 1'b1; in_fetch_req = 1'b0; in_pc_load = 1'b0; in_pc_value = 9'd0;
      tick(); tick();
      reset = 1'b0;
      check("rst_pc", 32'(out_pc), 32'd0);
      check("rst_addr", 32'(out_code_mem_addr), 32'd0);
      check("rst_ir", 32'(out_ir), 32'd0);
      check("rst_valid", 32'(out_ir_valid), 32'd0);
      check("rst_busy", 32'(out_busy), 32'd0);

      do_fetch("f0", 16'h4A11, 9'h001);
      load_pc(9'h1F0);
      check("addr_eq_pc", 32'(out_code_mem_addr), 32'h1F0);
      do_fetch("f1f0", 16'hE3F0, 9'h1F1);
      load_pc(9'h1FF);
      do_fetch("wrap", 16'h8000, 9'h000);

      // Load during WAIT aborts the fetch
      load_pc(9'h005);
      in_fetch_req = 1'b1; tick(); in_fetch_req = 1'b0;
      in_pc_load = 1'b1; in_pc_value = 9'h020; tick(); in_pc_load = 1'b0;
      check("abw_pc", 32'(out_pc), 32'h020);
      check("abw_busy", 32'(out_busy), 32'd0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin pulses += int'(out_ir_valid); tick(); end
      check("abw_pulses", 32'(pulses), 32'd0);
      check("abw_ir", 32'(out_ir), 32'h8000);

      // Load during CAPTURE discards the data
      load_pc(9'h005);
      in_fetch_req = 1'b1; tick(); in_fetch_req = 1'b0;
      tick();
      check("abc_busy_cap", 32'(out_busy), 32'd1);
      in_pc_load = 1'b1; in_pc_value = 9'h020; tick(); in_pc_load = 1'b0;
      check("abc_pc", 32'(out_pc), 32'h020);
      check("abc_busy", 32'(out_busy), 32'd0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin pulses += int'(out_ir_valid); tick(); end
      check("abc_pulses", 32'(pulses), 32'd0);
      check("abc_ir", 32'(out_ir), 32'h8000);

      // Re-requests while busy are dropped
      load_pc(9'h003);
      in_fetch_req = 1'b1; tick(); tick(); in_fetch_req = 1'b0;
      tick();
      check("drop_v", 32'(out_ir_valid), 32'd1);
      check("drop_ir", 32'(out_ir), 32'h0BEE);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin tick(); pulses += int'(out_ir_valid); end
      check("drop_pulses", 32'(pulses), 32'd0);
      check("drop_pc", 32'(out_pc), 32'h004);

      // Load beats fetch in IDLE
      in_pc_load = 1'b1; in_pc_value = 9'h010; in_fetch_req = 1'b1;
      tick();
      in_pc_load = 1'b0; in_fetch_req = 1'b0;
      check("prec_pc", 32'(out_pc), 32'h010);
      check("prec_busy", 32'(out_busy), 32'd0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin tick(); pulses += int'(out_ir_valid); end
      check("prec_pulses", 32'(pulses), 32'd0);

`ifdef IFU_PREFETCH_EN
      rom[9'h000] = 16'h0001;
      rom[9'h001] = 16'h0002;
      load_pc(9'h000);
      do_fetch("pf_a", 16'h0001, 9'h001);
      tick(); tick(); tick();
      in_fetch_req = 1'b1; tick(); in_fetch_req = 1'b0;
      check("pf_hit_v", 32'(out_ir_valid), 32'd1);
      check("pf_hit_ir", 32'(out_ir), 32'h0002);
      check("pf_hit_pc", 32'(out_pc), 32'h002);
      check("pf_hit_busy", 32'(out_busy), 32'd0);
      tick();
      check("pf_hit_v0", 32'(out_ir_valid), 32'd0);
      tick(); tick(); tick();
      load_pc(9'h000);
      do_fetch("pf_ld", 16'h0001, 9'h001);
`endif

      // Reset during WAIT discards the pending fetch
      load_pc(9'h003);
      in_fetch_req = 1'b1; tick(); in_fetch_req = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      check("rw_ir", 32'(out_ir), 32'd0);
      check("rw_pc", 32'(out_pc), 32'd0);
      check("rw_busy", 32'(out_busy), 32'd0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin pulses += int'(out_ir_valid); tick(); end
      check("rw_pulses", 32'(pulses), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
